// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields into 32-bit instruction words and streams them out with sequential addresses.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [6:0]                     op_i,
    input  logic [4:0]                     rd_i,
    input  logic [4:0]                     rs1_i,
    input  logic [4:0]                     rs2_i,
    input  logic [2:0]                     funct3_i,
    input  logic [6:0]                     funct7_i,
    input  logic [31:0]                    imm_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [31:0]                    instr_o,
    output logic [31:0]                    addr_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           fmt_err_o,
    output logic                           range_err_o,
    output logic                           done_o
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_JALR = 7'h67;
    localparam logic [6:0] OP_U    = 7'h37;
    localparam logic [6:0] OP_S    = 7'h23;
    localparam logic [6:0] OP_B    = 7'h63;
    localparam logic [6:0] OP_J    = 7'h6F;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    function automatic logic [31:0] encode_word(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [20:0] imm
    );
        logic [31:0] w;
        case (op)
            OP_R:         w = {f7, rs2, rs1, f3, rd, op};
            OP_I, OP_JALR: w = {imm[11:0], rs1, f3, rd, op};
            OP_U:         w = {imm[19:0], rd, op};
            OP_S:         w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_B:         w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_J:         w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:      w = NOP;
        endcase
        return w;
    endfunction

    function automatic logic fmt_unsupported(input logic [6:0] op);
        logic bad;
        case (op)
            OP_R, OP_I, OP_JALR, OP_U, OP_S, OP_B, OP_J: bad = 1'b0;
            default:                                     bad = 1'b1;
        endcase
        return bad;
    endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // The immediate must survive truncation to the format's field and sign-extension back.
    function automatic logic imm_out_of_range(input logic [6:0] op, input logic signed [31:0] imm);
        logic bad;
        case (op)
            OP_I, OP_JALR, OP_S: bad = (imm != {{20{imm[11]}}, imm[11:0]});
            OP_U:                bad = (imm != {{12{imm[19]}}, imm[19:0]});
            OP_B:                bad = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            OP_J:                bad = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:             bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    logic [1:0]  state;
    logic        accept;
    logic        deliver;
    logic        last_deliver;
    logic [31:0] instr_p0;
    logic        fmt_err_p0;
    logic        range_err_p0;
    logic        unused_imm_hi;

    assign unused_imm_hi = ^imm_i[31:21];

    // Stage p0: combinational encode of the presented field bundle
    assign instr_p0   = encode_word(op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i[20:0]);
    assign fmt_err_p0 = fmt_unsupported(op_i);
`ifdef INSTR_ENC_RANGE_CHECK_EN
    assign range_err_p0 = imm_out_of_range(op_i, signed'(imm_i));
`else
    assign range_err_p0 = 1'b0;
`endif

    assign out_valid_o  = (state == ST_HOLD);
    assign done_o       = (state == ST_DONE);
    assign in_ready_o   = (state != ST_DONE) && (!out_valid_o || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign deliver      = out_valid_o && out_ready_i;
    assign last_deliver = deliver && (count_o == LAST_CNT);

    // Stage p1: output register and stream control
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            instr_o     <= 32'h0;
            addr_o      <= BASE_ADDR;
            count_o     <= '0;
            fmt_err_o   <= 1'b0;
            range_err_o <= 1'b0;
        end else if (clear_i) begin
            state   <= ST_EMPTY;
            addr_o  <= BASE_ADDR;
            count_o <= '0;
        end else begin
            if (deliver) begin
                count_o <= count_o + 1'b1;
                // The final word's address is kept so addr_o never runs past the window.
                if (!last_deliver) begin
                    addr_o <= addr_o + 32'd4;
                end
            end

            case (state)
                ST_EMPTY: if (accept) state <= ST_HOLD;
                ST_HOLD: begin
                    if (last_deliver) begin
                        state <= ST_DONE;
                    end else if (deliver && !accept) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_EMPTY;
            endcase

            if (accept && !last_deliver) begin
                instr_o     <= instr_p0;
                fmt_err_o   <= fmt_err_p0;
                range_err_o <= range_err_p0;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded RISC-V fields (opcode, registers, functs, 32-bit immediate) into 32-bit instruction words; the exact inverse of the immediate/format decode in the single-cycle datapath. Sits between the testbench/boot program source and the instruction memory loader. Emits words over a valid/ready stream with a sequential write address. Stops after a configurable number of words until cleared.

## Interface
- BASE_ADDR, 32'h0040_0000, address of the first emitted word
- DEPTH, 64, number of words emitted before the block enters DONE (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- clear_i  in  1  synchronous restart: back to EMPTY, address to BASE_ADDR
- in_valid_i  in  1  field bundle valid
- in_ready_o  out  1  block can accept a bundle this cycle
- op_i  in  7  opcode
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3;  funct7_i  in  7
- imm_i  in  32  immediate as the datapath sees it after decode
- out_valid_o  out  1  instr_o/addr_o valid
- out_ready_i  in  1  consumer accepts word
- instr_o  out  32  encoded instruction
- addr_o  out  32  byte address of instr_o
- count_o  out  $clog2(DEPTH+1)  words delivered since reset/clear
- fmt_err_o  out  1  unsupported opcode in current word
- range_err_o  out  1  immediate not representable (macro-dependent)
- done_o  out  1  DEPTH words delivered

## Operation
- Encoding: instr[6:0]=op_i for every format.
- R (0x33): {funct7, rs2, rs1, funct3, rd, op}.
- I (0x13, 0x67): {imm[11:0], rs1, funct3, rd, op}.
- U (0x37): {imm[19:0], rd, op}. U immediate is the unshifted 20-bit value.
- S (0x23): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
- B (0x63): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
- J (0x6F): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Any other opcode: instr_o=32'h0000_0013 (nop), fmt_err_o=1.
- Output register only. in_ready_o = (state≠DONE) && (!out_valid_o || out_ready_i).
- Accept: in_valid_i && in_ready_o loads instr_o and the error flags, and sets out_valid_o.
- Deliver: out_valid_o && out_ready_i. Then count_o+1 and addr_o+4.
- FSM:
  - EMPTY: out_valid_o=0. Goes to HOLD on accept.
  - HOLD: out_valid_o=1. Deliver without accept → EMPTY. Deliver with accept → stays HOLD. Deliver that makes count_o reach DEPTH → DONE.
  - DONE: in_ready_o=0, out_valid_o=0, done_o=1.
- clear_i has priority over everything except reset. It drops any held word (not counted) and enters EMPTY with addr_o=BASE_ADDR and count_o=0.
- addr_o never wraps: DONE is reached before the address passes BASE_ADDR+4·(DEPTH−1).
- Reset (mid-stream included): out_valid_o=0, instr_o=0, addr_o=BASE_ADDR, count_o=0, fmt_err_o=0, range_err_o=0, done_o=0, state EMPTY. in_ready_o=1 one cycle after reset deasserts.

## Timing
- Latency input→output: 1 cycle (word visible the cycle after accept).
- Throughput: 1 word/cycle while out_ready_i=1.
- While out_valid_o && !out_ready_i: instr_o, addr_o and the flags are held stable and in_ready_o=0.
- addr_o and count_o update on the clock edge of the deliver. addr_o is always the address of the currently held word.
- done_o asserts the cycle after the DEPTH-th deliver.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined:
  - I/S: range_err_o=1 if imm_i ≠ sext(imm_i[11:0]).
  - U: range_err_o=1 if imm_i ≠ sext(imm_i[19:0]).
  - B: range_err_o=1 if imm_i ≠ sext(imm_i[12:0]) or imm_i[0]=1.
  - J: range_err_o=1 if imm_i ≠ sext(imm_i[20:0]) or imm_i[0]=1.
  - Word is still packed from the truncated bits.
- Undefined: no check logic; range_err_o tied 0.

## Test plan
- op 0x13, rd=1, rs1=0, f3=0, imm=5 → instr_o=32'h0050_0093 one cycle later, addr_o=32'h0040_0000.
- op 0x23, rs1=1, rs2=2, f3=2, imm=8 → 32'h0020_A423. op 0x63, rs1=rs2=0, f3=0, imm=−4 → 32'hFE00_0EE3.
- op 0x6F, rd=1, imm=8 → 32'h0080_00EF. op 0x7F → 32'h0000_0013 with fmt_err_o=1.
- op 0x13, imm=32'h800, macro defined → range_err_o=1, instr_o=32'h8000_0013. Same stimulus without the macro → range_err_o=0.
- out_ready_i=0 for 5 cycles with out_valid_o=1 → instr_o/addr_o stable, in_ready_o=0. Then release with back-to-back inputs → one word/cycle, addr_o +4 each.
- DEPTH=4: after 4 delivers, done_o=1 and in_ready_o=0. clear_i while HOLD, asserted together with out_ready_i → word dropped, count_o=0, addr_o=BASE_ADDR. Reset low mid-stream → all outputs at reset values.
